// File: rtl/sccb_slave_regfile.sv
// sccb_slave_regfile: SCCB/I2C responder modelling the OV7670 register interface over a 256 x 8 register file.
// Optional SCCB_SLAVE_AUTOINC_EN: sub-address auto-increments across burst write and read bytes.
module sccb_slave_regfile #(
   parameter logic [7:0]  DEV_ADDR = 8'h42,
   parameter int unsigned SDA_HOLD = 8,
   parameter logic [7:0]  PID_VAL  = 8'h76,
   parameter logic [7:0]  VER_VAL  = 8'h73
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       I2C_SCLK,
   inout  wire        I2C_SDAT,
   output logic       oREG_WE,
   output logic [7:0] oREG_ADDR,
   output logic [7:0] oREG_WDATA,
   output logic       oBUSY
);

   localparam logic [7:0] PID_ADDR = 8'h0A;
   localparam logic [7:0] VER_ADDR = 8'h0B;

   typedef enum logic [3:0] {
      IDLE, DEV, ACK_DEV, SUB, ACK_SUB, WR, ACK_WR, RD, RACK, IGNORE
   } stateT;

   stateT       state;
   logic [1:0]  sclSync;
   logic [1:0]  sdaSync;
   logic        sclPrev;
   logic        sdaPrev;
   logic        sclNow;
   logic        sdaNow;
   logic        sclRise;
   logic        sclFall;
   logic        startDet;
   logic        stopDet;
   logic [2:0]  bitCnt;
   logic [7:0]  shiftReg;
   logic [7:0]  subAddr;
   logic        rwBit;
   logic        sdaLow;
   logic        sdaNext;
   logic [7:0]  holdCnt;
   logic [7:0]  regFile [256];
   logic [7:0]  rxByte;

   function automatic logic [7:0] nextAddr(input logic [7:0] a);
`ifdef SCCB_SLAVE_AUTOINC_EN
      return a + 8'd1;
`else
      return a;
`endif
   endfunction

   // Open-drain drive: only ever pull low.
   assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;

   // Two-stage synchronizers plus one history stage for edge detection.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         sclSync <= 2'b11;
         sdaSync <= 2'b11;
         sclPrev <= 1'b1;
         sdaPrev <= 1'b1;
      end else begin
         sclSync <= {sclSync[0], I2C_SCLK};
         sdaSync <= {sdaSync[0], I2C_SDAT};
         sclPrev <= sclSync[1];
         sdaPrev <= sdaSync[1];
      end
   end

   assign sclNow   = sclSync[1];
   assign sdaNow   = sdaSync[1];
   assign sclRise  = sclNow & ~sclPrev;
   assign sclFall  = ~sclNow & sclPrev;
   // SCL must be high on both samples, so an SDA edge coincident with an SCL edge stays data.
   assign startDet = sclNow & sclPrev & sdaPrev & ~sdaNow;
   assign stopDet  = sclNow & sclPrev & ~sdaPrev & sdaNow;
   assign rxByte   = {shiftReg[6:0], sdaNow};

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state      <= IDLE;
         bitCnt     <= 3'd0;
         shiftReg   <= 8'h00;
         subAddr    <= 8'h00;
         rwBit      <= 1'b0;
         sdaLow     <= 1'b0;
         sdaNext    <= 1'b0;
         holdCnt    <= 8'd0;
         oREG_WE    <= 1'b0;
         oREG_ADDR  <= 8'h00;
         oREG_WDATA <= 8'h00;
         oBUSY      <= 1'b0;
         for (int i = 0; i < 256; i++) begin
            regFile[8'(i)] <= 8'h00;
         end
         regFile[PID_ADDR] <= PID_VAL;
         regFile[VER_ADDR] <= VER_VAL;
      end else begin
         oREG_WE <= 1'b0;

         // Delayed SDA update: the drive decided at an SCL fall is applied SDA_HOLD cycles later.
         if (holdCnt != 8'd0) begin
            holdCnt <= holdCnt - 8'd1;
            if (holdCnt == 8'd1) begin
               sdaLow <= sdaNext;
            end
         end

         if (startDet) begin
            state   <= DEV;
            bitCnt  <= 3'd0;
            sdaLow  <= 1'b0;
            holdCnt <= 8'd0;
         end else if (stopDet) begin
            state   <= IDLE;
            sdaLow  <= 1'b0;
            holdCnt <= 8'd0;
            oBUSY   <= 1'b0;
         end else begin
            if (sclFall) begin
               holdCnt <= 8'(SDA_HOLD);
               case (state)
                  ACK_DEV, ACK_SUB, ACK_WR: sdaNext <= 1'b1;
                  RD:                       sdaNext <= ~shiftReg[7];
                  default:                  sdaNext <= 1'b0;
               endcase
            end

            if (sclRise) begin
               case (state)
                  DEV: begin
                     shiftReg <= rxByte;
                     bitCnt   <= bitCnt + 3'd1;
                     if (bitCnt == 3'd7) begin
                        if (shiftReg[6:0] == DEV_ADDR[7:1]) begin
                           state <= ACK_DEV;
                           rwBit <= sdaNow;
                           oBUSY <= 1'b1;
                        end else begin
                           state <= IGNORE;
                           oBUSY <= 1'b0;
                        end
                     end
                  end
                  ACK_DEV: begin
                     bitCnt <= 3'd0;
                     if (rwBit) begin
                        shiftReg  <= regFile[subAddr];
                        oREG_ADDR <= subAddr;
                        state     <= RD;
                     end else begin
                        state <= SUB;
                     end
                  end
                  SUB: begin
                     shiftReg <= rxByte;
                     bitCnt   <= bitCnt + 3'd1;
                     if (bitCnt == 3'd7) begin
                        subAddr   <= rxByte;
                        oREG_ADDR <= rxByte;
                        state     <= ACK_SUB;
                     end
                  end
                  ACK_SUB: begin
                     bitCnt <= 3'd0;
                     state  <= WR;
                  end
                  WR: begin
                     shiftReg <= rxByte;
                     bitCnt   <= bitCnt + 3'd1;
                     if (bitCnt == 3'd7) begin
                        // Read-only ID registers still ACK the byte but never change.
                        if (subAddr != PID_ADDR && subAddr != VER_ADDR) begin
                           regFile[subAddr] <= rxByte;
                           oREG_WE          <= 1'b1;
                           oREG_ADDR        <= subAddr;
                           oREG_WDATA       <= rxByte;
                        end
                        subAddr <= nextAddr(subAddr);
                        state   <= ACK_WR;
                     end
                  end
                  ACK_WR: begin
                     bitCnt <= 3'd0;
                     state  <= WR;
                  end
                  RD: begin
                     shiftReg <= {shiftReg[6:0], 1'b0};
                     bitCnt   <= bitCnt + 3'd1;
                     if (bitCnt == 3'd7) begin
                        subAddr <= nextAddr(subAddr);
                        state   <= RACK;
                     end
                  end
                  RACK: begin
                     bitCnt <= 3'd0;
                     if (!sdaNow) begin
                        shiftReg  <= regFile[subAddr];
                        oREG_ADDR <= subAddr;
                        state     <= RD;
                     end else begin
                        state <= IGNORE;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// tb_sccb_slave_regfile: bit-banged SCCB master with a transaction-level register-file model.
`timescale 1ns/1ps
module tb_sccb_slave_regfile;

   localparam int unsigned HP = 32;
   localparam int unsigned QP = HP / 2;

   logic       iCLK = 1'b0;
   logic       iRST;
   logic       sclDrv;
   logic       mLow;
   wire        sdat;
   logic       oREG_WE;
   logic [7:0] oREG_ADDR;
   logic [7:0] oREG_WDATA;
   logic       oBUSY;

   int         nCompared = 0;
   int         nMismatch = 0;
   logic [7:0] model [256];
   logic [7:0] modelSub;
   logic [15:0] weLog [$];
   logic [15:0] weExp [$];
   logic [7:0] wrBytes [$];
   int         slaveLowCnt;
   logic       busySeen;

   assign sdat = mLow ? 1'b0 : 1'bz;
   pullup (sdat);

   sccb_slave_regfile dut (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .I2C_SCLK   (sclDrv),
      .I2C_SDAT   (sdat),
      .oREG_WE    (oREG_WE),
      .oREG_ADDR  (oREG_ADDR),
      .oREG_WDATA (oREG_WDATA),
      .oBUSY      (oBUSY)
   );

   always #20 iCLK = ~iCLK;

   always @(negedge iCLK) begin
      if (oREG_WE) weLog.push_back({oREG_ADDR, oREG_WDATA});
      if (oBUSY) busySeen = 1'b1;
   end

   always @(posedge iCLK) begin
      if (!mLow && sdat == 1'b0) slaveLowCnt++;
   end

   initial begin
      #(64'd6_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatch++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] nextSub(input logic [7:0] a);
`ifdef SCCB_SLAVE_AUTOINC_EN
      return a + 8'd1;
`else
      return a;
`endif
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
      model[8'h0A] = 8'h76;
      model[8'h0B] = 8'h73;
      modelSub = 8'h00;
   endtask

   task automatic waitCyc(input int unsigned n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic busStart();
      mLow = 1'b0;
      waitCyc(QP);
      sclDrv = 1'b1;
      waitCyc(QP);
      mLow = 1'b1;
      waitCyc(QP);
      sclDrv = 1'b0;
   endtask

   task automatic busStop();
      waitCyc(QP);
      mLow = 1'b1;
      waitCyc(QP);
      sclDrv = 1'b1;
      waitCyc(QP);
      mLow = 1'b0;
      waitCyc(QP);
   endtask

   task automatic clockBit(input logic b, output logic s);
      waitCyc(QP);
      mLow = ~b;
      waitCyc(QP);
      sclDrv = 1'b1;
      waitCyc(QP);
      s = sdat;
      waitCyc(QP);
      sclDrv = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clockBit(b[3'(i)], s);
      clockBit(1'b1, ack);
   endtask

   task automatic recvByte(input logic ackIt, output logic [7:0] d);
      logic s;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         clockBit(1'b1, s);
         d = {d[6:0], s};
      end
      clockBit(~ackIt, s);
   endtask

   // Write sub-address then every byte of wrBytes; the model applies each byte per the register rules.
   task automatic writeRegs(input logic [7:0] sub, input string tag);
      logic ack;
      weLog.delete();
      weExp.delete();
      busStart();
      sendByte(8'h42, ack);
      checkVal({tag, "_ackdev"}, 32'(ack), 32'd0);
      sendByte(sub, ack);
      checkVal({tag, "_acksub"}, 32'(ack), 32'd0);
      modelSub = sub;
      foreach (wrBytes[k]) begin
         sendByte(wrBytes[k], ack);
         checkVal({tag, "_ackwr"}, 32'(ack), 32'd0);
         if (modelSub != 8'h0A && modelSub != 8'h0B) begin
            model[modelSub] = wrBytes[k];
            weExp.push_back({modelSub, wrBytes[k]});
         end
         modelSub = nextSub(modelSub);
      end
      busStop();
      waitCyc(4);
      checkVal({tag, "_wecnt"}, 32'(weLog.size()), 32'(weExp.size()));
      for (int k = 0; k < weExp.size() && k < weLog.size(); k++)
         checkVal({tag, "_we"}, 32'(weLog[k]), 32'(weExp[k]));
   endtask

   task automatic readCur(input int n, input string tag);
      logic ack;
      logic [7:0] d;
      busStart();
      sendByte(8'h43, ack);
      checkVal({tag, "_ackrd"}, 32'(ack), 32'd0);
      for (int k = 0; k < n; k++) begin
         recvByte(k != n - 1, d);
         checkVal({tag, "_data"}, 32'(d), 32'(model[modelSub]));
         modelSub = nextSub(modelSub);
      end
      busStop();
   endtask

   task automatic readRegs(input logic [7:0] sub, input int n, input string tag);
      logic ack;
      busStart();
      sendByte(8'h42, ack);
      checkVal({tag, "_ackdev"}, 32'(ack), 32'd0);
      sendByte(sub, ack);
      checkVal({tag, "_acksub"}, 32'(ack), 32'd0);
      busStop();
      modelSub = sub;
      readCur(n, tag);
   endtask

   initial begin
      logic ack;
      logic s;
      logic [7:0] sub;
      int len;

      iRST = 1'b1;
      sclDrv = 1'b1;
      mLow = 1'b0;
      slaveLowCnt = 0;
      busySeen = 1'b0;
      modelReset();
      waitCyc(5);
      iRST = 1'b0;
      waitCyc(5);

      checkVal("rst_we", 32'(oREG_WE), 32'd0);
      checkVal("rst_addr", 32'(oREG_ADDR), 32'd0);
      checkVal("rst_wdata", 32'(oREG_WDATA), 32'd0);
      checkVal("rst_busy", 32'(oBUSY), 32'd0);
      checkVal("rst_sda", 32'(sdat), 32'd1);

      readRegs(8'h0A, 1, "pid");
      readRegs(8'h0B, 1, "ver");

      busySeen = 1'b0;
      wrBytes.delete();
      wrBytes.push_back(8'h80);
      writeRegs(8'h12, "wr12");
      checkVal("busy_seen", 32'(busySeen), 32'd1);
      checkVal("busy_after_stop", 32'(oBUSY), 32'd0);
      readRegs(8'h12, 1, "rb12");

      wrBytes.delete();
      wrBytes.push_back(8'h55);
      writeRegs(8'h0A, "wr0a");
      readRegs(8'h0A, 1, "rb0a");

      // Foreign device address: no drive, no busy, no writes.
      weLog.delete();
      busySeen = 1'b0;
      slaveLowCnt = 0;
      busStart();
      sendByte(8'h60, ack);
      checkVal("ign_nack", 32'(ack), 32'd1);
      sendByte(8'h12, ack);
      sendByte(8'h99, ack);
      busStop();
      waitCyc(4);
      checkVal("ign_sda_low", 32'(slaveLowCnt), 32'd0);
      checkVal("ign_busy", 32'(busySeen), 32'd0);
      checkVal("ign_we", 32'(weLog.size()), 32'd0);
      readRegs(8'h12, 1, "ign_rb12");

      wrBytes.delete();
      wrBytes.push_back(8'h11);
      wrBytes.push_back(8'h22);
      writeRegs(8'hFF, "wrap");
      readRegs(8'hFF, 1, "rbff");
      readRegs(8'h00, 1, "rb00");

      for (int it = 0; it < 4; it++) begin
         sub = 8'($urandom_range(0, 255));
         len = int'($urandom_range(1, 3));
         wrBytes.delete();
         for (int k = 0; k < len; k++) wrBytes.push_back(8'($urandom));
         writeRegs(sub, $sformatf("rnd%0d", it));
         readRegs(sub, len, $sformatf("rnd%0d_burst", it));
         readRegs(8'($urandom), 1, $sformatf("rnd%0d_any", it));
      end

      // Reset while the responder is pulling SDA low for read bit 3 of 0x0A (0x76).
      busStart();
      sendByte(8'h42, ack);
      sendByte(8'h0A, ack);
      busStop();
      busStart();
      sendByte(8'h43, ack);
      checkVal("mid_ackrd", 32'(ack), 32'd0);
      for (int i = 0; i < 4; i++) clockBit(1'b1, s);
      waitCyc(QP);
      mLow = 1'b0;
      waitCyc(QP);
      sclDrv = 1'b1;
      waitCyc(QP);
      checkVal("mid_b3_drive", 32'(sdat), 32'd0);
      iRST = 1'b1;
      @(posedge iCLK);
      #1;
      checkVal("mid_rst_release", 32'(sdat), 32'd1);
      checkVal("mid_rst_busy", 32'(oBUSY), 32'd0);
      @(negedge iCLK);
      iRST = 1'b0;
      waitCyc(QP);
      sclDrv = 1'b0;
      busStop();
      modelReset();
      readCur(1, "post_rst_sub0");
      readRegs(8'h0A, 1, "post_rst_pid");
      readRegs(8'h12, 1, "post_rst_12");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
